// File: rtl/spi_slave_reg_ctrl.sv
// Command/data transaction controller between the SPI slave shifter and the register bus.
// Define SPI_SLAVE_REG_CTRL_STATUS_EN to map the all-ones address onto the local error status.
module spi_slave_reg_ctrl #(
    parameter int p_data_width  = 16,
    parameter int p_count_width = $clog2(p_data_width) + 1,
    parameter int p_addr_width  = 7,
    parameter int p_bus_timeout = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_slv_data_valid,
    input  logic [p_data_width-1:0]  ip_slv_data_in,
    input  logic                     i_slv_error,
    output logic [p_data_width-1:0]  op_slv_data_out,
    output logic [p_count_width-1:0] op_slv_data_count,
    output logic                     o_bus_req,
    output logic                     o_bus_we,
    output logic [p_addr_width-1:0]  op_bus_addr,
    output logic [p_data_width-1:0]  op_bus_wdata,
    input  logic                     i_bus_ack,
    input  logic [p_data_width-1:0]  ip_bus_rdata,
    output logic                     o_err_sticky,
    output logic [7:0]               op_err_count,
    input  logic                     i_clr_err,
    output logic                     o_idle
);
    localparam int c_tmo_width = $clog2(p_bus_timeout + 1);

    typedef enum logic [1:0] {S_CMD, S_RD_BUS, S_DATA, S_WR_BUS} state_t;

    state_t                  state, state_n;
    logic                    rw, rw_n;
    logic [p_addr_width-1:0] addr, addr_n;
    logic                    abort, abort_n;
    logic [c_tmo_width-1:0]  tmo, tmo_n;
    logic                    req_n;
    logic [p_data_width-1:0] dout_n, wdata_n, status_word;
    logic                    valid_frame, err_frame, ack, tmo_hit;
    logic                    status_hit, status_sel, err_event, clr_event;

    assign valid_frame       = i_slv_data_valid && !i_slv_error;
    assign err_frame         = i_slv_data_valid && i_slv_error;
    assign ack               = o_bus_req && i_bus_ack;
    assign tmo_hit           = (tmo == c_tmo_width'(p_bus_timeout));
    assign op_slv_data_count = p_count_width'(p_data_width);
    assign op_bus_addr       = addr;
    assign o_bus_we          = o_bus_req && !rw;
    assign o_idle            = (state == S_CMD);

`ifdef SPI_SLAVE_REG_CTRL_STATUS_EN
    assign status_hit = &ip_slv_data_in[p_addr_width-1:0];
    assign status_sel = &addr;
`else
    assign status_hit = 1'b0;
    assign status_sel = 1'b0;
`endif

    always_comb begin
        status_word      = '0;
        status_word[8:0] = {o_err_sticky, op_err_count};
    end

    always_comb begin
        state_n   = state;
        rw_n      = rw;
        addr_n    = addr;
        abort_n   = abort;
        tmo_n     = tmo;
        req_n     = o_bus_req;
        dout_n    = op_slv_data_out;
        wdata_n   = op_bus_wdata;
        err_event = 1'b0;
        clr_event = 1'b0;
        case (state)
            S_CMD: begin
                if (err_frame) begin
                    err_event = 1'b1;
                end else if (valid_frame) begin
                    rw_n    = ip_slv_data_in[p_data_width-1];
                    addr_n  = ip_slv_data_in[p_addr_width-1:0];
                    tmo_n   = '0;
                    abort_n = 1'b0;
                    if (status_hit) begin
                        state_n = S_DATA;
                        if (ip_slv_data_in[p_data_width-1]) dout_n = status_word;
                        else                                clr_event = 1'b1;
                    end else begin
                        state_n = ip_slv_data_in[p_data_width-1] ? S_RD_BUS : S_DATA;
                    end
                end
            end
            S_RD_BUS: begin
                // A frame here means the master ran ahead; finish the read but drop its data.
                if (i_slv_data_valid) begin
                    err_event = 1'b1;
                    abort_n   = 1'b1;
                end
                if (ack) begin
                    req_n   = 1'b0;
                    state_n = (abort || i_slv_data_valid) ? S_CMD : S_DATA;
                    dout_n  = (abort || i_slv_data_valid) ? '0 : ip_bus_rdata;
                end else if (tmo_hit) begin
                    req_n     = 1'b0;
                    err_event = 1'b1;
                    dout_n    = '0;
                    state_n   = (abort || i_slv_data_valid) ? S_CMD : S_DATA;
                end else begin
                    req_n = 1'b1;
                    tmo_n = tmo + c_tmo_width'(1);
                end
            end
            S_DATA: begin
                if (err_frame) begin
                    err_event = 1'b1;
                    dout_n    = '0;
                    state_n   = S_CMD;
                end else if (valid_frame) begin
                    if (rw) begin
                        dout_n  = '0;
                        state_n = S_CMD;
                    end else if (status_sel) begin
                        state_n = S_CMD;
                    end else begin
                        wdata_n = ip_slv_data_in;
                        tmo_n   = '0;
                        state_n = S_WR_BUS;
                    end
                end
            end
            S_WR_BUS: begin
                if (i_slv_data_valid) err_event = 1'b1;
                if (ack) begin
                    req_n   = 1'b0;
                    state_n = S_CMD;
                end else if (tmo_hit) begin
                    req_n     = 1'b0;
                    err_event = 1'b1;
                    state_n   = S_CMD;
                end else begin
                    req_n = 1'b1;
                    tmo_n = tmo + c_tmo_width'(1);
                end
            end
            default: state_n = S_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_CMD;
            rw              <= 1'b0;
            addr            <= '0;
            abort           <= 1'b0;
            tmo             <= '0;
            o_bus_req       <= 1'b0;
            op_slv_data_out <= '0;
            op_bus_wdata    <= '0;
        end else begin
            state           <= state_n;
            rw              <= rw_n;
            addr            <= addr_n;
            abort           <= abort_n;
            tmo             <= tmo_n;
            o_bus_req       <= req_n;
            op_slv_data_out <= dout_n;
            op_bus_wdata    <= wdata_n;
        end
    end

    // Clearing wins over an error reported in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || i_clr_err || clr_event) begin
            o_err_sticky <= 1'b0;
            op_err_count <= '0;
        end else if (err_event) begin
            o_err_sticky <= 1'b1;
            if (op_err_count != 8'hFF) op_err_count <= op_err_count + 8'd1;
        end
    end
endmodule

// File: doc/spi_slave_reg_ctrl.md
Name: spi_slave_reg_ctrl

Overview:
- Transaction controller that sits between the SPI slave shifter and the on-chip register bus.
- Decodes two-frame SPI transactions: a command frame followed by a data frame.
- For writes, issues a register-bus write with the data from the second frame.
- For reads, fetches register data over the bus between frames and loads it into the shifter's transmit word for the second frame. Also tracks protocol errors.

Parameters:
- p_data_width, 16, SPI frame length in bits; equals the shifter buffer length.
- p_count_width, $clog2(p_data_width)+1, width of the shifter bit-count port.
- p_addr_width, 7, register address width; must be <= p_data_width-1.
- p_bus_timeout, 255, maximum cycles to wait for i_bus_ack.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_slv_data_valid  in  1  shifter frame-complete pulse
- ip_slv_data_in  in  p_data_width  received frame from the shifter
- i_slv_error  in  1  shifter frame-timeout flag
- op_slv_data_out  out  p_data_width  transmit word presented to the shifter
- op_slv_data_count  out  p_count_width  frame bit count; constant p_data_width
- o_bus_req  out  1  register-bus request
- o_bus_we  out  1  1 = write, 0 = read
- op_bus_addr  out  p_addr_width  register address
- op_bus_wdata  out  p_data_width  write data
- i_bus_ack  in  1  bus completion, single-cycle
- ip_bus_rdata  in  p_data_width  read data, valid with i_bus_ack
- o_err_sticky  out  1  any error since last clear
- op_err_count  out  8  saturating error counter
- i_clr_err  in  1  clears o_err_sticky and op_err_count
- o_idle  out  1  FSM in S_CMD

Behaviour:
- Command word format:
  - bit[p_data_width-1] = rw (1 = read).
  - bits[p_addr_width-1:0] = address.
  - All other bits are ignored.
- Reset values: every output is 0, except op_slv_data_count = p_data_width and o_idle = 1. Internal address, rw and timeout counter are cleared. Reset mid-transaction drops o_bus_req the following cycle; no bus completion is waited for.
- Frame classification: a valid frame is a cycle with i_slv_data_valid=1 and i_slv_error=0. i_slv_data_valid=1 with i_slv_error=1 is an error frame.
- Error frame, in any state: the frame is discarded and an error is recorded.
  - From S_CMD or S_DATA: go to S_CMD.
  - From a bus state: the bus handshake completes first, then go to S_CMD.
- FSM states and transitions:
  - S_CMD, on a valid frame: latch rw and address.
    - rw=1: go to S_RD_BUS.
    - rw=0: go to S_DATA.
  - S_RD_BUS:
    - o_bus_req=1, o_bus_we=0 from the cycle after entry.
    - On i_bus_ack: op_slv_data_out <= ip_bus_rdata, drop req, go to S_DATA.
    - Timeout (counter reaches p_bus_timeout): load 0, record error, go to S_DATA.
  - S_DATA, on a valid frame:
    - Read: the frame is the read-out; clear op_slv_data_out to 0 and go to S_CMD.
    - Write: op_bus_wdata <= ip_slv_data_in, go to S_WR_BUS.
  - S_WR_BUS:
    - o_bus_req=1, o_bus_we=1 until i_bus_ack, then go to S_CMD.
    - Timeout: record error, go to S_CMD.
- Bus handshake rules:
  - While o_bus_req is high, addr, we and wdata are held stable.
  - req deasserts the cycle after ack.
  - At most one request is outstanding.
  - The timeout counter resets on entry to each bus state.
- Underrun: a valid frame arriving in S_RD_BUS means the master started the data frame too early.
  - Record an error.
  - Complete the bus read, discard rdata, keep op_slv_data_out = 0, go to S_CMD.
- Overrun: a valid frame arriving in S_WR_BUS is dropped and an error is recorded. The write still completes.
- Error recording and clearing:
  - Recording an error sets o_err_sticky and increments op_err_count, saturating at 255.
  - i_clr_err has priority over a same-cycle error: after the clear, both outputs read 0.
- Read latency: the first SCLK edge of the data frame must come at least (bus latency + 3) clk cycles after the command frame's i_slv_data_valid. This is because the shifter samples op_slv_data_out continuously while idle.

Optional Feature:
- Macro: SPI_SLAVE_REG_CTRL_STATUS_EN.
- When defined: a read command to address all-ones (2^p_addr_width-1) issues no bus request.
  - Next cycle, op_slv_data_out = {zero-pad, o_err_sticky, op_err_count}, then go to S_DATA.
  - A write to that address clears the error state (same effect as i_clr_err) without a bus access, then go to S_DATA → S_CMD as normal with no bus request.
- When undefined: address all-ones is an ordinary bus address.

Test Plan:
- Write: cmd frame 0x0012, then data frame 0xBEEF → exactly one req with we=1, addr=0x12, wdata=0xBEEF; after ack, o_idle=1 and no error.
- Read: cmd 0x8005, ack after 4 cycles with rdata 0xA5C3 → op_slv_data_out=0xA5C3 before data frame; after data frame, out=0 and o_idle=1.
- Bus timeout: read cmd 0x8001 with ack never asserted → req drops after 255 cycles, op_slv_data_out=0, op_err_count=1, o_err_sticky=1.
- Underrun: read cmd, then data frame valid 1 cycle later with ack at cycle 6 → err_count increments, returns to S_CMD with out=0, no second bus request.
- Error frame: i_slv_data_valid with i_slv_error=1 in S_DATA of a write → no bus request, S_CMD, err_count+1; 300 error frames → op_err_count saturates at 255; i_clr_err → 0.
- With SPI_SLAVE_REG_CTRL_STATUS_EN: after 2 errors, read cmd 0x807F → no o_bus_req, op_slv_data_out=0x0102.
